// File: rtl/lsu_dmem_master.sv
// Load/store initiator between the RV32I execute stage and a word-wide data memory.
// Sub-word loads are extracted from the full word; sub-word stores use read-modify-write.
module lsu_dmem_master #(
    parameter int unsigned ALIGN_CHECK = 1,
    parameter logic [31:0] ERR_RDATA   = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned HW   = 16;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          state;
    logic [2:0]      f3_q;
    logic [1:0]      lo_q;
    logic [HW-1:0]   wdata_q;
    logic            we_q;
    logic            mem_we_q;

    logic            req_illegal;
    logic            req_misaligned;

    // Sign/zero-extend the selected lane of a memory word for a load.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [XLEN-1:0] w,
        input logic [2:0]      f3,
        input logic [1:0]      lo
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_B:    load_extract = {{24{b[7]}}, b};
            F3_BU:   load_extract = {24'h000000, b};
            F3_H:    load_extract = {{16{h[15]}}, h};
            F3_HU:   load_extract = {16'h0000, h};
            default: load_extract = w;
        endcase
    endfunction

    // Replace the addressed byte/half lane of a memory word with store data.
    function automatic logic [XLEN-1:0] store_merge(
        input logic [XLEN-1:0] w,
        input logic [2:0]      f3,
        input logic [1:0]      lo,
        input logic [HW-1:0]   d
    );
        logic [XLEN-1:0] r;
        r = w;
        if (f3 == F3_B) begin
            r[{lo, 3'b000} +: 8] = d[7:0];
        end else if (f3 == F3_H) begin
            if (lo[1]) r[31:16] = d;
            else       r[15:0]  = d;
        end
        store_merge = r;
    endfunction

    // Classify the incoming request as illegal or misaligned.
    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: req_illegal = 1'b0;
            F3_BU, F3_HU:     req_illegal = req_we;
            default:          req_illegal = 1'b1;
        endcase
        if (ALIGN_CHECK != 0) begin
            case (req_funct3)
                F3_H, F3_HU: req_misaligned = req_addr[0];
                F3_W:        req_misaligned = |req_addr[1:0];
                default:     req_misaligned = 1'b0;
            endcase
        end
    end

    // A reset asserted mid-write must never commit the write.
    assign mem_we = mem_we_q & ~reset;

    // Access sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            err        <= 1'b0;
            resp_rdata <= '0;
            mem_we_q   <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= '0;
            f3_q       <= '0;
            lo_q       <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        f3_q      <= req_funct3;
                        lo_q      <= req_addr[1:0];
                        wdata_q   <= req_wdata[HW-1:0];
                        we_q      <= req_we;
                        mem_a     <= {req_addr[31:2], 2'b00};
                        req_ready <= 1'b0;
                        if (req_illegal || req_misaligned) begin
                            resp_valid <= 1'b1;
                            err        <= 1'b1;
                            resp_rdata <= ERR_RDATA;
                            state      <= RESP;
                        end else if (req_we && (req_funct3 == F3_W)) begin
                            mem_we_q <= 1'b1;
                            mem_wd   <= req_wdata;
                            state    <= WRITE;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        mem_wd   <= store_merge(mem_rd, f3_q, lo_q, wdata_q);
                        mem_we_q <= 1'b1;
                        state    <= WRITE;
                    end else begin
                        resp_rdata <= load_extract(mem_rd, f3_q, lo_q);
                        resp_valid <= 1'b1;
                        err        <= 1'b0;
                        state      <= RESP;
                    end
                end
                WRITE: begin
                    mem_we_q   <= 1'b0;
                    resp_valid <= 1'b1;
                    err        <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    err        <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master with a small word memory model.
module tb_lsu_dmem_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [16];

    int errors = 0;
    int checks = 0;

    // Results of the last run_req transaction.
    int          r_lat;
    int          r_we_cnt;
    logic        r_ready_hi;
    logic [31:0] r_wd;
    logic [31:0] r_a;
    logic [31:0] r_rdata;
    logic        r_err;

    lsu_dmem_master #(.ALIGN_CHECK(1), .ERR_RDATA(32'h00000000)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .err        (err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[5:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[5:2]] <= mem_wd;
    end

    // Issue one request and observe it until its response (bounded).
    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        r_lat      = 0;
        r_we_cnt   = 0;
        r_ready_hi = 1'b0;
        r_wd       = 32'hx;
        r_a        = 32'hx;
        @(negedge clk);
        while (!resp_valid && r_lat < 8) begin
            if (mem_we) begin
                r_we_cnt++;
                r_wd = mem_wd;
                r_a  = mem_a;
            end
            if (req_ready) r_ready_hi = 1'b1;
            @(negedge clk);
            r_lat++;
        end
        if (mem_we) r_we_cnt++;
        if (req_ready) r_ready_hi = 1'b1;
        r_rdata = resp_rdata;
        r_err   = err;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
        checks++; if (mem_wd !== 32'h0) begin errors++; $display("FAIL reset_mem_wd got=%h exp=0", mem_wd); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        reset = 1'b0;
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b101};
        logic [31:0] adrs [5] = '{32'h05, 32'h05, 32'h06, 32'h04, 32'h04};
        logic [31:0] exps [5] = '{32'hFFFFFFEF, 32'h000000EF, 32'hFFFFABCD, 32'hABCDEF01, 32'h0000EF01};
        for (int i = 0; i < 5; i++) begin
            run_req(1'b0, f3s[i], adrs[i], 32'hDEADBEEF);
            checks++; if (r_rdata !== exps[i]) begin errors++; $display("FAIL load%0d_rdata got=%h exp=%h", i, r_rdata, exps[i]); end
            checks++; if (r_lat !== 1) begin errors++; $display("FAIL load%0d_latency got=%0d exp=1", i, r_lat); end
            checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL load%0d_err got=%b exp=0", i, r_err); end
            checks++; if (r_we_cnt !== 0) begin errors++; $display("FAIL load%0d_we_count got=%0d exp=0", i, r_we_cnt); end
        end
    endtask

    task automatic test_sub_store();
        run_req(1'b1, 3'b000, 32'h06, 32'h00000012);
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL sb_latency got=%0d exp=2", r_lat); end
        checks++; if (r_we_cnt !== 1) begin errors++; $display("FAIL sb_we_count got=%0d exp=1", r_we_cnt); end
        checks++; if (r_wd !== 32'hAB12EF01) begin errors++; $display("FAIL sb_mem_wd got=%h exp=ab12ef01", r_wd); end
        checks++; if (r_a !== 32'h04) begin errors++; $display("FAIL sb_mem_a got=%h exp=00000004", r_a); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL sb_err got=%b exp=0", r_err); end
        checks++; if (r_ready_hi !== 1'b0) begin errors++; $display("FAIL sb_ready_busy got=%b exp=0", r_ready_hi); end
        checks++; if (r_rdata !== 32'h0000EF01) begin errors++; $display("FAIL sb_rdata_hold got=%h exp=0000ef01", r_rdata); end
        run_req(1'b0, 3'b010, 32'h04, 32'h0);
        checks++; if (r_rdata !== 32'hAB12EF01) begin errors++; $display("FAIL sb_readback got=%h exp=ab12ef01", r_rdata); end
        run_req(1'b1, 3'b001, 32'h0A, 32'h1111BEEF);
        checks++; if (r_wd !== 32'hBEEF0000) begin errors++; $display("FAIL sh_mem_wd got=%h exp=beef0000", r_wd); end
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL sh_latency got=%0d exp=2", r_lat); end
        run_req(1'b0, 3'b010, 32'h08, 32'h0);
        checks++; if (r_rdata !== 32'hBEEF0000) begin errors++; $display("FAIL sh_readback got=%h exp=beef0000", r_rdata); end
    endtask

    task automatic test_sw();
        run_req(1'b1, 3'b010, 32'h08, 32'h12345678);
        checks++; if (r_lat !== 1) begin errors++; $display("FAIL sw_latency got=%0d exp=1", r_lat); end
        checks++; if (r_we_cnt !== 1) begin errors++; $display("FAIL sw_we_count got=%0d exp=1", r_we_cnt); end
        checks++; if (r_wd !== 32'h12345678) begin errors++; $display("FAIL sw_mem_wd got=%h exp=12345678", r_wd); end
        checks++; if (r_a !== 32'h08) begin errors++; $display("FAIL sw_mem_a got=%h exp=00000008", r_a); end
        checks++; if (r_ready_hi !== 1'b0) begin errors++; $display("FAIL sw_ready_busy got=%b exp=0", r_ready_hi); end
        checks++; if (r_rdata !== 32'hBEEF0000) begin errors++; $display("FAIL sw_rdata_hold got=%h exp=beef0000", r_rdata); end
        checks++; if (mem[2] !== 32'h12345678) begin errors++; $display("FAIL sw_mem_word got=%h exp=12345678", mem[2]); end
    endtask

    task automatic test_errors();
        logic        wes  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s  [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] adrs [4] = '{32'h05, 32'h0A, 32'h04, 32'h04};
        for (int i = 0; i < 4; i++) begin
            run_req(wes[i], f3s[i], adrs[i], 32'hFFFFFFFF);
            checks++; if (r_lat !== 0) begin errors++; $display("FAIL err%0d_latency got=%0d exp=0", i, r_lat); end
            checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL err%0d_err got=%b exp=1", i, r_err); end
            checks++; if (r_rdata !== 32'h0) begin errors++; $display("FAIL err%0d_rdata got=%h exp=0", i, r_rdata); end
            checks++; if (r_we_cnt !== 0) begin errors++; $display("FAIL err%0d_we_count got=%0d exp=0", i, r_we_cnt); end
        end
        checks++; if (mem[1] !== 32'hAB12EF01) begin errors++; $display("FAIL err_mem_untouched got=%h exp=ab12ef01", mem[1]); end
    endtask

    task automatic test_reset_in_write();
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h04;
        req_wdata  = 32'h00000099;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_write_pre_we got=%b exp=1", mem_we); end
        reset = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_write_we_gated got=%b exp=0", mem_we); end
        @(negedge clk);
        reset = 1'b0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_write_resp got=%b exp=0", resp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_write_ready got=%b exp=1", req_ready); end
        checks++; if (mem[1] !== 32'hAB12EF01) begin errors++; $display("FAIL rst_write_mem got=%h exp=ab12ef01", mem[1]); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_write_resp_late got=%b exp=0", resp_valid); end
    endtask

    task automatic test_back_to_back();
        logic seen;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h04;
        req_wdata  = 32'h0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL b2b_first_resp got=%b exp=1", seen); end
        checks++; if (resp_rdata !== 32'hAB12EF01) begin errors++; $display("FAIL b2b_lw_rdata got=%h exp=ab12ef01", resp_rdata); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_resp got=%b exp=0", req_ready); end
        req_we     = 1'b1;
        req_addr   = 32'h08;
        req_wdata  = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle got=%b exp=1", req_ready); end
        checks++; if (mem_a !== 32'h04) begin errors++; $display("FAIL b2b_not_yet_accepted got=%h exp=00000004", mem_a); end
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL b2b_sw_we got=%b exp=1", mem_we); end
        checks++; if (mem_a !== 32'h08) begin errors++; $display("FAIL b2b_sw_a got=%h exp=00000008", mem_a); end
        checks++; if (mem_wd !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_sw_wd got=%h exp=cafef00d", mem_wd); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_sw_resp got=%b exp=1", resp_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_sw_err got=%b exp=0", err); end
        @(negedge clk);
        checks++; if (mem[2] !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_sw_mem got=%h exp=cafef00d", mem[2]); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_resp_one_cycle got=%b exp=0", resp_valid); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[1] = 32'hABCDEF01;
        test_reset();
        test_loads();
        test_sub_store();
        test_sw();
        test_errors();
        test_reset_in_write();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
